ext_irq_dispatcher: RTL and testbench

Device-side counterpart of the core's interrupt controller. Collects up to P_SRC_N device interrupt request lines, latches rising edges as pending events, arbitrates among enabled pending sources, and presents one request at a time on the external interrupt handshake (ACTIVE/NUM/ACK). Sits between the peripheral interrupt lines and the core's external-interrupt input.

---
 rtl/ext_irq_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_ext_irq_dispatcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_dispatcher.sv
// ext_irq_dispatcher
//   Collects device interrupt request lines and latches their rising edges as
//   pending events. It arbitrates among the pending sources that are enabled
//   and presents one request at a time to the core over ACTIVE/NUM/ACK.
//
// Configuration macro:
//   IRQ_DISPATCH_ROUND_ROBIN_EN - if defined, arbitration is round-robin. The
//                                 search starts one past the last granted
//                                 source. If undefined, the lowest index wins.
//
// Ports:
//   iCLOCK        clock
//   inRESET       asynchronous active-low reset
//   iRESET_SYNC   synchronous reset (same effect as inRESET)
//   iIRQ_REQ      device request lines, rising-edge sensitive
//   iMASK_VALID   enable-table write strobe
//   iMASK_ENTRY   source index to write (out-of-range entries ignored)
//   iMASK_ENABLE  new enable bit for that entry
//   oEXT_ACTIVE   request valid toward the core
//   oEXT_NUM      source index of the current request
//   iEXT_ACK      one-cycle acceptance pulse from the core
//   oPENDING      pending-event status vector
module ext_irq_dispatcher #(
  parameter int unsigned P_SRC_N = 32
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic [P_SRC_N-1:0] iIRQ_REQ,
  input  logic               iMASK_VALID,
  input  logic [5:0]         iMASK_ENTRY,
  input  logic               iMASK_ENABLE,
  output logic               oEXT_ACTIVE,
  output logic [5:0]         oEXT_NUM,
  input  logic               iEXT_ACK,
  output logic [P_SRC_N-1:0] oPENDING
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [P_SRC_N-1:0] req_prev_q, req_prev_d;
  logic [P_SRC_N-1:0] pending_q, pending_d;
  logic [P_SRC_N-1:0] enable_q, enable_d;
  logic [5:0]         num_q, num_d;

  logic [P_SRC_N-1:0] irq_event;
  logic [P_SRC_N-1:0] cand;
  logic               cand_any;
  logic [5:0]         winner;
  logic               ack_accept;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [5:0] lowest_set(input logic [P_SRC_N-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = int'(P_SRC_N) - 1; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  assign irq_event  = iIRQ_REQ & ~req_prev_q;
  assign cand       = pending_q & enable_q;
  assign cand_any   = |cand;
  assign ack_accept = (state_q == StReq) && iEXT_ACK;

`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
  localparam logic [6:0] SrcN = 7'(P_SRC_N);

  logic [5:0]         ptr_q, ptr_d;
  logic [P_SRC_N-1:0] cand_rot;
  logic [6:0]         win_sum;
  logic [6:0]         win_next;

  // Rotate so that bit 0 is the search start. The lowest set bit of the
  // rotated vector is then the first candidate at or after the pointer.
  assign cand_rot = (cand >> ptr_q) | (cand << (P_SRC_N - 32'(ptr_q)));

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, lowest_set(cand_rot)};
    if (win_sum >= SrcN) win_sum = win_sum - SrcN;
    winner   = win_sum[5:0];
    win_next = win_sum + 7'd1;
    if (win_next == SrcN) win_next = '0;
  end
`else
  assign winner = lowest_set(cand);
`endif

  always_comb begin
    req_prev_d = iIRQ_REQ;
    state_d    = state_q;
    num_d      = num_q;
    enable_d   = enable_q;
    pending_d  = pending_q;
`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif

    // A matching compare never hits entries at or above P_SRC_N.
    for (int i = 0; i < int'(P_SRC_N); i++) begin
      if (iMASK_VALID && (iMASK_ENTRY == 6'(i))) enable_d[i] = iMASK_ENABLE;
      if (ack_accept && (num_q == 6'(i))) pending_d[i] = 1'b0;
    end
    // A new edge on the source being acknowledged must survive the clear.
    pending_d = pending_d | irq_event;

    unique case (state_q)
      StIdle: begin
        if (cand_any) begin
          num_d   = winner;
          state_d = StReq;
`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
          ptr_d   = win_next[5:0];
`endif
        end
      end
      StReq:   if (iEXT_ACK) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (iRESET_SYNC) begin
      req_prev_d = '0;
      state_d    = StIdle;
      num_d      = '0;
      enable_d   = '1;
      pending_d  = '0;
`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
      ptr_d      = '0;
`endif
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= StIdle;
      req_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '1;
      num_q      <= '0;
`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      num_q      <= num_d;
`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign oEXT_ACTIVE = (state_q == StReq);
  assign oEXT_NUM    = num_q;
  assign oPENDING    = pending_q;

endmodule

// File: tb/tb_ext_irq_dispatcher.sv
// Directed bench for ext_irq_dispatcher (P_SRC_N = 32). Inputs change 1 time
// unit after the rising edge, and outputs are checked at that same point.
module tb_ext_irq_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        rst_sync;
  logic [31:0] irq_req;
  logic        mask_valid;
  logic [5:0]  mask_entry;
  logic        mask_enable;
  logic        ext_active;
  logic [5:0]  ext_num;
  logic        ext_ack;
  logic [31:0] pending;

  int n_total = 0;
  int n_bad   = 0;

`ifdef IRQ_DISPATCH_ROUND_ROBIN_EN
  localparam logic [5:0] PrioFirst  = 6'd7;
  localparam logic [5:0] PrioSecond = 6'd3;
`else
  localparam logic [5:0] PrioFirst  = 6'd3;
  localparam logic [5:0] PrioSecond = 6'd7;
`endif

  ext_irq_dispatcher #(.P_SRC_N(32)) u_dut (
    .iCLOCK       (clk),
    .inRESET      (rst_n),
    .iRESET_SYNC  (rst_sync),
    .iIRQ_REQ     (irq_req),
    .iMASK_VALID  (mask_valid),
    .iMASK_ENTRY  (mask_entry),
    .iMASK_ENABLE (mask_enable),
    .oEXT_ACTIVE  (ext_active),
    .oEXT_NUM     (ext_num),
    .iEXT_ACK     (ext_ack),
    .oPENDING     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ack_pulse();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
  endtask

  task automatic mask_write(input logic [5:0] entry, input logic en);
    mask_valid  = 1'b1;
    mask_entry  = entry;
    mask_enable = en;
    tick();
    mask_valid  = 1'b0;
  endtask

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    rst_sync    = 1'b0;
    irq_req     = '0;
    mask_valid  = 1'b0;
    mask_entry  = '0;
    mask_enable = 1'b0;
    ext_ack     = 1'b0;

    #2;
    chk("rst_active", 64'(ext_active), 64'd0);
    chk("rst_num", 64'(ext_num), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single event on source 5. The line stays high afterwards.
    irq_req[5] = 1'b1;
    tick();
    chk("t1_pend", 64'(pending), 64'h20);
    chk("t1_act_early", 64'(ext_active), 64'd0);
    tick();
    chk("t1_act", 64'(ext_active), 64'd1);
    chk("t1_num", 64'(ext_num), 64'd5);
    repeat (6) tick();
    chk("t1_hold_act", 64'(ext_active), 64'd1);
    chk("t1_hold_num", 64'(ext_num), 64'd5);
    ack_pulse();
    chk("t1_gap_act", 64'(ext_active), 64'd0);
    chk("t1_gap_pend", 64'(pending), 64'd0);
    tick();
    tick();
    chk("t1_level_act", 64'(ext_active), 64'd0);

    // Two sources in the same cycle.
    irq_req[3] = 1'b1;
    irq_req[7] = 1'b1;
    tick();
    chk("t2_pend", 64'(pending), 64'h88);
    tick();
    chk("t2_act1", 64'(ext_active), 64'd1);
    chk("t2_num1", 64'(ext_num), 64'(PrioFirst));
    ack_pulse();
    chk("t2_gap_act", 64'(ext_active), 64'd0);
    chk("t2_gap_pend", 64'(pending), 64'(32'd1 << PrioSecond));
    tick();
    chk("t2_idle_act", 64'(ext_active), 64'd0);
    tick();
    chk("t2_act2", 64'(ext_active), 64'd1);
    chk("t2_num2", 64'(ext_num), 64'(PrioSecond));
    ack_pulse();
    chk("t2_pend_clr", 64'(pending), 64'd0);
    irq_req = '0;
    tick();
    tick();

    // Masking of source 9.
    mask_write(6'd9, 1'b0);
    irq_req[9] = 1'b1;
    tick();
    chk("t3_pend", 64'(pending), 64'h200);
    tick();
    tick();
    chk("t3_masked", 64'(ext_active), 64'd0);
    mask_write(6'd9, 1'b1);
    chk("t3_unmask_k1", 64'(ext_active), 64'd0);
    tick();
    chk("t3_unmask_act", 64'(ext_active), 64'd1);
    chk("t3_unmask_num", 64'(ext_num), 64'd9);
    ack_pulse();
    irq_req[9] = 1'b0;
    tick();
    // Entry 63 is out of range and must not alias onto source 31.
    mask_write(6'd63, 1'b0);
    irq_req[31] = 1'b1;
    tick();
    tick();
    chk("t3_e63_act", 64'(ext_active), 64'd1);
    chk("t3_e63_num", 64'(ext_num), 64'd31);
    ack_pulse();
    irq_req[31] = 1'b0;
    tick();
    tick();

    // A new edge arrives in the cycle that acknowledges that same source.
    irq_req[2] = 1'b1;
    tick();
    irq_req[2] = 1'b0;
    tick();
    chk("t4_act1", 64'(ext_active), 64'd1);
    chk("t4_num1", 64'(ext_num), 64'd2);
    ext_ack    = 1'b1;
    irq_req[2] = 1'b1;
    tick();
    ext_ack    = 1'b0;
    irq_req[2] = 1'b0;
    chk("t4_pend_kept", 64'(pending), 64'h4);
    chk("t4_gap_act", 64'(ext_active), 64'd0);
    tick();
    tick();
    chk("t4_act2", 64'(ext_active), 64'd1);
    chk("t4_num2", 64'(ext_num), 64'd2);
    ack_pulse();
    chk("t4_pend_clr", 64'(pending), 64'd0);
    tick();
    tick();

    // An ACK while IDLE must not clear the pending bit of a disabled source.
    // Here NUM still holds 2.
    mask_write(6'd2, 1'b0);
    irq_req[2] = 1'b1;
    tick();
    irq_req[2] = 1'b0;
    tick();
    chk("t5_pend", 64'(pending), 64'h4);
    ack_pulse();
    chk("t5_ack_idle_pend", 64'(pending), 64'h4);
    chk("t5_ack_idle_act", 64'(ext_active), 64'd0);
    irq_req[4] = 1'b1;
    tick();
    tick();
    chk("t5_lvl_act", 64'(ext_active), 64'd1);
    chk("t5_lvl_num", 64'(ext_num), 64'd4);
    ack_pulse();
    repeat (4) tick();
    chk("t5_lvl_once_pend", 64'(pending), 64'h4);
    chk("t5_lvl_once_act", 64'(ext_active), 64'd0);

    // Reset in the middle of a request.
    irq_req = 32'h42;
    tick();
    tick();
    chk("t6_act", 64'(ext_active), 64'd1);
    chk("t6_pend", 64'(pending), 64'h46);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_act", 64'(ext_active), 64'd0);
    chk("t6_arst_pend", 64'(pending), 64'd0);
    tick();
    rst_n = 1'b1;
    // Lines still high after reset produce events on the first cycle.
    tick();
    chk("t6_post_pend", 64'(pending), 64'h42);
    tick();
    chk("t6_post_act", 64'(ext_active), 64'd1);
    rst_sync = 1'b1;
    #1;
    chk("t6_srst_wait", 64'(ext_active), 64'd1);
    tick();
    rst_sync = 1'b0;
    chk("t6_srst_act", 64'(ext_active), 64'd0);
    chk("t6_srst_pend", 64'(pending), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
